// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state type, length clamp and reset-default configuration for seq_pattern_detector
package seq_det_pkg;
  typedef enum logic {FILL, RUN} state_e;
  localparam int DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN = 8'h01;
  localparam int DEF_LEN = 2;
  localparam bit DEF_OVERLAP = 1'b1;
  localparam int DEF_MATCH_CNT_W = 8;
  function automatic int clamp_len(input int len, input int max_len);
    return len < 1 ? 1 : len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/seq_det_cmp.sv
// seq_det_cmp: masked equality of the low len bits of hist against pattern
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = 4
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);
  logic [MAX_LEN-1:0] mask;
  assign mask = ~({MAX_LEN{1'b1}} << len);
  assign eq = ~|((hist ^ pattern) & mask);
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable serial pattern detector with registered one-cycle match pulse
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = 4,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int DEFAULT_LEN = DEF_LEN,
  parameter bit DEFAULT_OVERLAP = DEF_OVERLAP
`ifdef SEQDET_COUNT_EN
  , parameter int MATCH_CNT_W = DEF_MATCH_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y
`ifdef SEQDET_COUNT_EN
  , output logic [MATCH_CNT_W-1:0] match_count
`endif
);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_n;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_n;
  logic ovl_q, ovl_d, y_q, y_d, eq, match;
  state_e state_q, state_d;
  assign hist_n = MAX_LEN'({hist_q, din});
  assign y = y_q;
  seq_det_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
    .hist(hist_n), .pattern(pat_q), .len(len_q), .eq(eq)
  );
  // en gates every use of din so an undriven line cannot leak into state
  always_comb begin
    fill_n = (state_q == RUN) ? len_q : fill_q + LEN_W'(1);
    match = en && !cfg_load && (fill_n == len_q) && eq;
    pat_d = cfg_load ? cfg_pattern : pat_q;
    len_d = cfg_load ? LEN_W'(clamp_len(int'(cfg_len), MAX_LEN)) : len_q;
    ovl_d = cfg_load ? cfg_overlap : ovl_q;
    hist_d = cfg_load ? '0 : en ? hist_n : hist_q;
    fill_d = cfg_load ? '0 : !en ? fill_q : (match && !ovl_q) ? '0 : fill_n;
    state_d = (fill_d == len_d) ? RUN : FILL;
    y_d = match;
  end
`ifdef SEQDET_COUNT_EN
  logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;
  assign match_count = cnt_q;
  always_comb cnt_d = cfg_load ? '0 : (match && !(&cnt_q)) ? cnt_q + MATCH_CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= DEFAULT_PATTERN;
      len_q <= RST_LEN;
      ovl_q <= DEFAULT_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      state_q <= FILL;
      y_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      state_q <= state_d;
      y_q <= y_d;
    end
  end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;
  logic clk = 1'b0, reset, en, din, cfg_load, cfg_overlap, y;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  int checks = 0, errors = 0;
`ifdef SEQDET_COUNT_EN
  logic [1:0] match_count;
`endif
  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN(8)
`ifdef SEQDET_COUNT_EN
    , .MATCH_CNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .y(y)
`ifdef SEQDET_COUNT_EN
    , .match_count(match_count)
`endif
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic ey, input string tag);
    @(negedge clk);
    cfg_load = 1'b0; en = e; din = d;
    @(posedge clk); #1;
    chk(32'(y), 32'(ey), tag);
  endtask

  task automatic run(input int n, input logic [15:0] bits, input logic [15:0] ys, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, bits[n-1-i], ys[n-1-i], $sformatf("%s[%0d]", tag, i));
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(negedge clk);
    cfg_load = 1'b1; en = 1'b1; din = 1'b1;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    @(posedge clk); #1;
    chk(32'(y), 0, "load_y");
`ifdef SEQDET_COUNT_EN
    chk(32'(match_count), 0, "load_cnt");
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk(32'(y), 0, "rst_pulse_y");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(32'(y), 0, "rst_y");
`ifdef SEQDET_COUNT_EN
    chk(32'(match_count), 0, "rst_cnt");
`endif
    @(negedge clk);
    reset = 1'b0;
    // default "01", len 2, overlapping
    run(7, 16'b1010101, 16'b0010101, "t1");
    load(8'h05, 4'd4, 1'b1);
    run(8, 16'b01010101, 16'b00010101, "t2_ovl");
    load(8'h05, 4'd4, 1'b0);
    run(8, 16'b01010101, 16'b00010001, "t2_novl");
    // enable gaps with toggling / unknown din
    load(8'h05, 4'd4, 1'b1);
    run(2, 16'b01, 16'b00, "t3_pre");
    for (int i = 0; i < 5; i++) step(1'b0, (i == 2) ? 1'bx : 1'(i % 2), 1'b0, $sformatf("t3_gap[%0d]", i));
    run(2, 16'b01, 16'b01, "t3_post");
    // reset mid-sequence restores defaults
    load(8'h05, 4'd4, 1'b1);
    run(3, 16'b010, 16'b000, "t4_pre");
    pulse_reset();
    run(3, 16'b101, 16'b001, "t4_post");
    #2 reset = 1'b1; en = 1'b0;
    #1 chk(32'(y), 0, "t4_async_drop");
    @(negedge clk);
    reset = 1'b0;
    // mid-stream reconfiguration and length clamps
    load(8'h05, 4'd4, 1'b1);
    run(2, 16'b01, 16'b00, "t5_pre");
    load(8'h06, 4'd3, 1'b1);
    run(3, 16'b110, 16'b001, "t5_len3");
    load(8'h01, 4'd0, 1'b1);
    run(3, 16'b011, 16'b011, "t5_len0");
    load(8'hA5, 4'd15, 1'b1);
    run(8, 16'hA5, 16'h01, "t5_len15");
`ifdef SEQDET_COUNT_EN
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, $sformatf("t6_y[%0d]", i));
      chk(32'(match_count), (i < 3) ? i + 1 : 3, $sformatf("t6_cnt[%0d]", i));
    end
    load(8'h01, 4'd1, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
